// File: rtl/store_buffer_if.sv
// Bundle of store, load-forward, drain and status signals between the MEM stage and the store buffer.
// master = pipeline / memory side, slave = the buffer.
interface store_buffer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;

  logic              drain_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, drain_en,
    input  st_ready, ld_hit, ld_data, mem_we, mem_waddr, mem_wdata, count, empty, full
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, drain_en,
    output st_ready, ld_hit, ld_data, mem_we, mem_waddr, mem_wdata, count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue between MEM stage and data memory: drains one store per permitted cycle
// and forwards the youngest matching buffered store to loads.
module store_buffer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst_n,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // Both decisions use pre-edge occupancy: no bypass when full, no same-edge drain when empty.
  assign push  = sb.st_valid && !full;
  assign pop   = sb.drain_en && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (pop) begin
        mem_we    <= 1'b1;
        mem_waddr <= addr_q[rd_ptr];
        mem_wdata <= data_q[rd_ptr];
      end else begin
        mem_we    <= 1'b0;
      end
    end
  end

  // NOTE: entry storage is deliberately not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= sb.st_addr;
      data_q[wr_ptr] <= sb.st_data;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  // NOTE: outputs get defaults first so the combinational block cannot infer a latch.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) &&
          (addr_q[rd_ptr + PTR_W'(k)][ADDR_W-1:2] == sb.ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[rd_ptr + PTR_W'(k)];
      end
    end
  end

  assign sb.st_ready  = !full;
  assign sb.ld_hit    = ld_hit;
  assign sb.ld_data   = ld_data;
  assign sb.mem_we    = mem_we;
  assign sb.mem_waddr = mem_waddr;
  assign sb.mem_wdata = mem_wdata;
  assign sb.count     = count;
  assign sb.empty     = empty;
  assign sb.full      = full;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus pushes expected memory writes into a queue,
// a negedge monitor pops and compares each mem_we pulse; status and forwarding are checked inline.
module tb_store_buffer;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;

  store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) sb ();

  store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory write must match the next expected store, in order.
  always @(negedge clk) begin
    if (rst_n && sb.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(sb.mem_waddr), 64'hDEAD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("drain_addr", 64'(sb.mem_waddr), 64'(e.addr));
        check("drain_data", 64'(sb.mem_wdata), 64'(e.data));
      end
    end
  end

  // Apply one cycle of stimulus at posedge+1, return at the next posedge+1.
  task automatic drive(input logic sv, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic dr, input logic exp_acc);
    sb.st_valid = sv;
    sb.st_addr  = a;
    sb.st_data  = d;
    sb.drain_en = dr;
    if (sv && exp_acc) exp_q.push_back('{addr: a, data: d});
    @(posedge clk); #1;
    sb.st_valid = 1'b0;
    sb.drain_en = 1'b0;
  endtask

  task automatic drain_n(input int n);
    sb.drain_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    sb.drain_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    sb.st_valid = 1'b0;
    sb.st_addr  = '0;
    sb.st_data  = '0;
    sb.ld_addr  = '0;
    sb.drain_en = 1'b0;
    #12;
    check("rst_count",    64'(sb.count),    64'd0);
    check("rst_empty",    64'(sb.empty),    64'd1);
    check("rst_full",     64'(sb.full),     64'd0);
    check("rst_st_ready", 64'(sb.st_ready), 64'd1);
    check("rst_mem_we",   64'(sb.mem_we),   64'd0);
    check("rst_ld_hit",   64'(sb.ld_hit),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Order and drain
    drive(1'b1, 7'h04, 32'h11, 1'b0, 1'b1);
    drive(1'b1, 7'h08, 32'h22, 1'b0, 1'b1);
    drive(1'b1, 7'h0C, 32'h33, 1'b0, 1'b1);
    check("order_count3", 64'(sb.count), 64'd3);
    drain_n(3);
    check("order_we_last",    64'(sb.mem_we),    64'd1);
    check("order_addr_last",  64'(sb.mem_waddr), 64'h0C);
    check("order_empty",      64'(sb.empty),     64'd1);
    @(posedge clk); #1;
    check("order_we_off",     64'(sb.mem_we),    64'd0);
    check("order_addr_hold",  64'(sb.mem_waddr), 64'h0C);

    // Forward youngest, low address bits ignored
    drive(1'b1, 7'h10, 32'hAA, 1'b0, 1'b1);
    drive(1'b1, 7'h12, 32'hBB, 1'b0, 1'b1);
    sb.ld_addr = 7'h10; #1;
    check("fwd_hit",       64'(sb.ld_hit),  64'd1);
    check("fwd_youngest",  64'(sb.ld_data), 64'hBB);
    sb.ld_addr = 7'h13; #1;
    check("fwd_lowbits",   64'(sb.ld_data), 64'hBB);
    sb.ld_addr = 7'h14; #1;
    check("fwd_miss_hit",  64'(sb.ld_hit),  64'd0);
    check("fwd_miss_data", 64'(sb.ld_data), 64'd0);
    drain_n(1);
    sb.ld_addr = 7'h10; #1;
    check("fwd_after_pop", 64'(sb.ld_data), 64'hBB);
    drain_n(1);
    // Entry sitting in mem_* registers is no longer searched
    check("fwd_mem_reg_excluded", 64'(sb.ld_hit), 64'd0);

    // Full: fifth store dropped, also when a drain happens on the same edge
    for (int i = 0; i < 4; i++) drive(1'b1, 7'(32'h20 + 4 * i), 32'(i + 1), 1'b0, 1'b1);
    check("full_flag",     64'(sb.full),     64'd1);
    check("full_st_ready", 64'(sb.st_ready), 64'd0);
    check("full_count",    64'(sb.count),    64'd4);
    drive(1'b1, 7'h7C, 32'h55, 1'b0, 1'b0);
    check("full_drop_count", 64'(sb.count), 64'd4);
    drive(1'b1, 7'h7C, 32'h55, 1'b1, 1'b0);
    check("full_nobypass_count", 64'(sb.count), 64'd3);
    drain_n(3);
    check("full_drained", 64'(sb.empty), 64'd1);
    @(posedge clk); #1;

    // Simultaneous enqueue and drain with count=2, wrapping the pointers
    drive(1'b1, 7'h40, 32'h100, 1'b0, 1'b1);
    drive(1'b1, 7'h44, 32'h101, 1'b0, 1'b1);
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 7'(32'h40 + 4 * i), 32'(32'h100 + i), 1'b1, 1'b1);
      check("simul_count", 64'(sb.count), 64'd2);
    end
    drain_n(2);
    check("simul_empty", 64'(sb.empty), 64'd1);
    @(posedge clk); #1;

    // Empty + enqueue + drain_en: new entry not drained on the same edge
    drive(1'b1, 7'h60, 32'hCAFE, 1'b1, 1'b1);
    check("empty_enq_we",    64'(sb.mem_we), 64'd0);
    check("empty_enq_count", 64'(sb.count),  64'd1);
    drive(1'b0, 7'h00, 32'h0, 1'b1, 1'b0);
    check("empty_enq_drain_we",   64'(sb.mem_we),    64'd1);
    check("empty_enq_drain_addr", 64'(sb.mem_waddr), 64'h60);

    // Asynchronous reset mid-stream discards queued stores
    drive(1'b1, 7'h30, 32'h301, 1'b0, 1'b1);
    drive(1'b1, 7'h34, 32'h302, 1'b0, 1'b1);
    drive(1'b1, 7'h38, 32'h303, 1'b0, 1'b1);
    sb.ld_addr = 7'h34; #1;
    check("pre_rst_hit", 64'(sb.ld_hit), 64'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_count", 64'(sb.count),     64'd0);
    check("mid_rst_empty", 64'(sb.empty),     64'd1);
    check("mid_rst_we",    64'(sb.mem_we),    64'd0);
    check("mid_rst_waddr", 64'(sb.mem_waddr), 64'd0);
    check("mid_rst_hit",   64'(sb.ld_hit),    64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drain_n(4);
    check("post_rst_empty", 64'(sb.empty), 64'd1);
    check("post_rst_we",    64'(sb.mem_we), 64'd0);
    check("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
